ascon_serial_io: RTL and testbench
==================================

// Module: ascon_serial_io
// PURPOSE
//  Parametrised serial-load / serial-drain front end for the masked Ascon AEAD core.
//  - Inputs: W bits per beat per share for key, nonce, AD and PT, plus NR random lanes, under a valid/ready handshake.
//  - Core control: presents parallel share buses to the core and issues a one-cycle start pulse.
//  - Outputs: snapshots ciphertext/tag on core done, then streams them W bits per beat with backpressure.
// PARAMETERS
//  K       128  key length in bits
//  L       80   associated-data length in bits
//  Y       80   plaintext/ciphertext length in bits
//  SHARES  3    Boolean shares per secret input (1..3)
//  W       1    serial lane width in bits (1,2,4,8); K, L, Y, 64 and 128 must be multiples of W
//  NR      7    number of 64-bit random lanes
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous active-high reset
//  load_valid   in   1         input beat present
//  in_ready     out  1         block accepts input beats (LOAD state)
//  key_si       in   SHARES*W  key share lanes; share s = [s*W +: W]
//  nonce_si     in   SHARES*W  nonce share lanes (128-bit nonce)
//  ad_si        in   SHARES*W  associated-data share lanes
//  pt_si        in   SHARES*W  plaintext share lanes
//  rnd_si       in   NR*W      random lanes
//  start        in   1         encryption request
//  busy         out  1         high in RUN and DRAIN
//  core_key     out  SHARES*K  key shares to core; share s = [s*K +: K]
//  core_nonce   out  SHARES*128  nonce shares to core
//  core_ad      out  SHARES*L  AD shares to core
//  core_pt      out  SHARES*Y  PT shares to core
//  core_rnd     out  NR*64     random words to core
//  core_start   out  1         one-cycle start pulse to core
//  core_done    in   1         core result valid
//  core_ct      in   Y         core ciphertext
//  core_tag     in   128       core tag
//  out_ready    in   1         downstream accepts an output beat
//  ct_so        out  W         ciphertext beat
//  ct_valid     out  1         ct_so valid
//  tag_so       out  W         tag beat
//  tag_valid    out  1         tag_so valid
// BEHAVIOUR
//  - Reset:
//    - state=LOAD; all shift registers, beat counters and outputs cleared to 0.
//    - Consequently in_ready=1 and busy=0.
//  - FSM: LOAD -> ARMED -> RUN -> DRAIN -> LOAD.
//  - LOAD:
//    - A beat transfers when load_valid=1; there are no gaps in the count.
//    - Beat counter b runs from 0 to MAXB-1, where MAXB = max(K,128,L,Y,64)/W.
//    - Field of F bits updates only when b < F/W: reg <= {reg[F-W-1:0], lane}, i.e. MSB-first.
//    - The same rule applies per share and per random lane (F=64).
//    - On the transfer with b = MAXB-1: go to ARMED next cycle; in_ready drops that same next cycle.
//  - ARMED:
//    - Input registers hold; load_valid is ignored.
//    - start=1 -> next cycle core_start=1 for exactly one cycle, and state=RUN.
//  - RUN:
//    - Wait for core_done=1.
//    - On that cycle, core_ct and core_tag are captured into output shift registers; state=DRAIN next cycle.
//    - Core buses stay stable from ARMED through DRAIN.
//  - DRAIN:
//    - Drain counter d starts at 0.
//    - Validity: ct_valid = (d < Y/W); tag_valid = (d < 128/W).
//    - Data order is LSB-first: ct_so = ct_sh[W-1:0], tag_so = tag_sh[W-1:0].
//    - A beat transfers when out_ready=1 and either valid is high; on transfer, registers shift right by W and d++.
//    - out_ready=0 holds all outputs unchanged (no loss, no duplication).
//    - When ct_valid or tag_valid is 0, the corresponding *_so is driven 0.
//    - After the beat with d = max(Y,128)/W - 1, return to LOAD with b=0.
//    - Input registers are not cleared; a full new load overwrites them.
//  - Ignored events:
//    - start outside ARMED (including during LOAD or on the same cycle as the final load beat).
//    - core_done outside RUN.
//    - load_valid outside LOAD.
//  - rst mid-operation (any state): next cycle equals the reset state; a pending core_start is suppressed.
//  - Latencies:
//    - start -> core_start: 1 cycle.
//    - core_done -> first valid output beat: 1 cycle.
// TESTING
//  1. Defaults; 128 beats with load_valid=1 and known vectors (key share0 = 0x000102..0F):
//     -> ARMED after beat 128; in_ready=0; core_key[127:0]=0x000102..0F; core_ad/core_pt/core_rnd equal shifted vectors.
//  2. load_valid toggling every other cycle -> 256 cycles to ARMED; core buses identical to test 1.
//  3. start pulsed in LOAD (ignored, state unchanged), then in ARMED -> core_start high exactly one cycle later, busy=1.
//  4. core_done with core_ct=0x1, core_tag=0x8000..0, out_ready=1:
//     -> first ct_so=1; ct_valid drops after 80 beats; tag_so=1 on beat 128; LOAD after 128 beats.
//     -> out_ready low 5 cycles mid-drain freezes ct_so/tag_so/d.
//  5. W=8, SHARES=1: load completes in 16 beats; drain is 10 ct beats and 16 tag beats; byte order LSB-first.
//  6. rst asserted in DRAIN at d=40 -> next cycle state=LOAD, in_ready=1, ct_valid=tag_valid=0, all buses 0.

Source files
------------

// File: rtl/ascon_serial_io_if.sv
// Handshake and bus bundle between the Ascon serial front end, its
// serial producers/consumers and the parallel masked core.
interface ascon_serial_io_if #(
   parameter int K      = 128,
   parameter int L      = 80,
   parameter int Y      = 80,
   parameter int SHARES = 3,
   parameter int W      = 1,
   parameter int NR     = 7
);
   logic                  load_valid;
   logic                  in_ready;
   logic [SHARES*W-1:0]   key_si;
   logic [SHARES*W-1:0]   nonce_si;
   logic [SHARES*W-1:0]   ad_si;
   logic [SHARES*W-1:0]   pt_si;
   logic [NR*W-1:0]       rnd_si;
   logic                  start;
   logic                  busy;
   logic [SHARES*K-1:0]   core_key;
   logic [SHARES*128-1:0] core_nonce;
   logic [SHARES*L-1:0]   core_ad;
   logic [SHARES*Y-1:0]   core_pt;
   logic [NR*64-1:0]      core_rnd;
   logic                  core_start;
   logic                  core_done;
   logic [Y-1:0]          core_ct;
   logic [127:0]          core_tag;
   logic                  out_ready;
   logic [W-1:0]          ct_so;
   logic                  ct_valid;
   logic [W-1:0]          tag_so;
   logic                  tag_valid;

   modport slave (
      input  load_valid, key_si, nonce_si, ad_si, pt_si, rnd_si, start,
             core_done, core_ct, core_tag, out_ready,
      output in_ready, busy, core_key, core_nonce, core_ad, core_pt, core_rnd,
             core_start, ct_so, ct_valid, tag_so, tag_valid
   );

   modport master (
      output load_valid, key_si, nonce_si, ad_si, pt_si, rnd_si, start,
             core_done, core_ct, core_tag, out_ready,
      input  in_ready, busy, core_key, core_nonce, core_ad, core_pt, core_rnd,
             core_start, ct_so, ct_valid, tag_so, tag_valid
   );
endinterface

// File: rtl/ascon_serial_io.sv
// Serial-load / serial-drain front end for the masked Ascon AEAD core:
// MSB-first share loading, one-cycle core start, LSB-first ct/tag drain.
module ascon_sio_lane #(
   parameter int F = 64,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [F-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= {q[F-W-1:0], din};
   end
endmodule

module ascon_serial_io #(
   parameter int K      = 128,
   parameter int L      = 80,
   parameter int Y      = 80,
   parameter int SHARES = 3,
   parameter int W      = 1,
   parameter int NR     = 7
) (
   input  logic             clk,
   input  logic             rst,
   ascon_serial_io_if.slave io
);
   localparam int M1   = (K > 128) ? K : 128;
   localparam int M2   = (M1 > L) ? M1 : L;
   localparam int M3   = (M2 > Y) ? M2 : Y;
   localparam int MAXB = ((M3 > 64) ? M3 : 64) / W;
   localparam int DMAX = ((Y > 128) ? Y : 128) / W;
   localparam int BW   = $clog2(MAXB + 1);
   localparam int DW   = $clog2(DMAX + 1);

   // Per-field beat limits: a field only shifts while its own bits are arriving.
   localparam logic [BW-1:0] KB    = BW'(K / W);
   localparam logic [BW-1:0] NB    = BW'(128 / W);
   localparam logic [BW-1:0] LB    = BW'(L / W);
   localparam logic [BW-1:0] YB    = BW'(Y / W);
   localparam logic [BW-1:0] RB    = BW'(64 / W);
   localparam logic [BW-1:0] LASTB = BW'(MAXB - 1);
   localparam logic [DW-1:0] CTD   = DW'(Y / W);
   localparam logic [DW-1:0] TGD   = DW'(128 / W);
   localparam logic [DW-1:0] LASTD = DW'(DMAX - 1);

   typedef enum logic [1:0] {LOAD, ARMED, RUN, DRAIN} state_t;

   state_t         state;
   logic [BW-1:0]  b;
   logic [DW-1:0]  d;
   logic [Y-1:0]   ct_sh;
   logic [127:0]   tag_sh;
   logic           in_ready_q, busy_q, core_start_q;
   logic           load_fire, ct_v, tag_v;

   logic [SHARES-1:0][K-1:0]   key_q;
   logic [SHARES-1:0][127:0]   non_q;
   logic [SHARES-1:0][L-1:0]   ad_q;
   logic [SHARES-1:0][Y-1:0]   pt_q;
   logic [NR-1:0][63:0]        rnd_q;

   assign load_fire = (state == LOAD) && io.load_valid;
   assign ct_v      = (state == DRAIN) && (d < CTD);
   assign tag_v     = (state == DRAIN) && (d < TGD);

   for (genvar s = 0; s < SHARES; s++) begin : g_sh
      ascon_sio_lane #(.F(K),   .W(W)) u_key (.clk(clk), .rst(rst), .en(load_fire && (b < KB)),
                                              .din(io.key_si[s*W +: W]),   .q(key_q[s]));
      ascon_sio_lane #(.F(128), .W(W)) u_non (.clk(clk), .rst(rst), .en(load_fire && (b < NB)),
                                              .din(io.nonce_si[s*W +: W]), .q(non_q[s]));
      ascon_sio_lane #(.F(L),   .W(W)) u_ad  (.clk(clk), .rst(rst), .en(load_fire && (b < LB)),
                                              .din(io.ad_si[s*W +: W]),    .q(ad_q[s]));
      ascon_sio_lane #(.F(Y),   .W(W)) u_pt  (.clk(clk), .rst(rst), .en(load_fire && (b < YB)),
                                              .din(io.pt_si[s*W +: W]),    .q(pt_q[s]));
   end

   for (genvar r = 0; r < NR; r++) begin : g_rnd
      ascon_sio_lane #(.F(64), .W(W)) u_rnd (.clk(clk), .rst(rst), .en(load_fire && (b < RB)),
                                             .din(io.rnd_si[r*W +: W]), .q(rnd_q[r]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD;
         b            <= '0;
         d            <= '0;
         ct_sh        <= '0;
         tag_sh       <= '0;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         core_start_q <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         case (state)
            LOAD: if (io.load_valid) begin
               if (b == LASTB) begin
                  b          <= '0;
                  state      <= ARMED;
                  in_ready_q <= 1'b0;
               end else begin
                  b <= b + 1'b1;
               end
            end
            ARMED: if (io.start) begin
               core_start_q <= 1'b1;
               busy_q       <= 1'b1;
               state        <= RUN;
            end
            RUN: if (io.core_done) begin
               ct_sh  <= io.core_ct;
               tag_sh <= io.core_tag;
               d      <= '0;
               state  <= DRAIN;
            end
            DRAIN: if (io.out_ready && (ct_v || tag_v)) begin
               ct_sh  <= ct_sh >> W;
               tag_sh <= tag_sh >> W;
               if (d == LASTD) begin
                  d          <= '0;
                  b          <= '0;
                  state      <= LOAD;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  d <= d + 1'b1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign io.in_ready   = in_ready_q;
   assign io.busy       = busy_q;
   assign io.core_start = core_start_q;
   assign io.core_key   = key_q;
   assign io.core_nonce = non_q;
   assign io.core_ad    = ad_q;
   assign io.core_pt    = pt_q;
   assign io.core_rnd   = rnd_q;
   assign io.ct_valid   = ct_v;
   assign io.tag_valid  = tag_v;
   assign io.ct_so      = ct_v  ? ct_sh[W-1:0]  : '0;
   assign io.tag_so     = tag_v ? tag_sh[W-1:0] : '0;
endmodule

// File: tb/tb_ascon_serial_io.sv
// Bench for ascon_serial_io: a W=1/3-share instance with randomized loads and
// drains against a positional reference model, plus a W=8/1-share instance.
module tb_ascon_serial_io;
   logic clk = 1'b0;
   logic rst, rst8;
   always #5 clk = ~clk;

   ascon_serial_io_if #(.K(128), .L(80), .Y(80), .SHARES(3), .W(1), .NR(7)) io1 ();
   ascon_serial_io_if #(.K(128), .L(80), .Y(80), .SHARES(1), .W(8), .NR(7)) io8 ();

   ascon_serial_io #(.K(128), .L(80), .Y(80), .SHARES(3), .W(1), .NR(7))
      dut1 (.clk(clk), .rst(rst), .io(io1));
   ascon_serial_io #(.K(128), .L(80), .Y(80), .SHARES(1), .W(8), .NR(7))
      dut8 (.clk(clk), .rst(rst8), .io(io8));

   int checks = 0;
   int errors = 0;

   // beat-order sequences: bit j is what goes on the lane during load beat j
   logic [127:0] sk[3], sn[3], sa[3], sp[3], sr[7];

   typedef struct {
      logic [79:0]  ct;
      logic [127:0] tag;
      int           probe;
      logic         ectv, etv, ect, etg;
   } drain_vec_t;
   drain_vec_t tbl[7];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Field value after a load: beat j lands at bit f-1-j (first beat is the MSB).
   function automatic logic [127:0] place(input logic [127:0] seq, input int f);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < f; j++) r[f-1-j] = seq[j];
      return r;
   endfunction

   function automatic logic [127:0] unplace(input logic [127:0] val, input int f);
      logic [127:0] s;
      s = rnd128();
      for (int j = 0; j < f; j++) s[j] = val[f-1-j];
      return s;
   endfunction

   task automatic rand_seqs();
      for (int s = 0; s < 3; s++) begin
         sk[s] = rnd128(); sn[s] = rnd128(); sa[s] = rnd128(); sp[s] = rnd128();
      end
      for (int r = 0; r < 7; r++) sr[r] = rnd128();
   endtask

   task automatic check_bus1(input string name);
      logic [383:0] ek, en;
      logic [239:0] ea, ep;
      logic [447:0] er;
      logic [127:0] t;
      for (int s = 0; s < 3; s++) begin
         t = place(sk[s], 128); ek[s*128 +: 128] = t;
         t = place(sn[s], 128); en[s*128 +: 128] = t;
         t = place(sa[s], 80);  ea[s*80 +: 80]   = t[79:0];
         t = place(sp[s], 80);  ep[s*80 +: 80]   = t[79:0];
      end
      for (int r = 0; r < 7; r++) begin
         t = place(sr[r], 64); er[r*64 +: 64] = t[63:0];
      end
      chk({name, "/key"},   io1.core_key,   ek);
      chk({name, "/nonce"}, io1.core_nonce, en);
      chk({name, "/ad"},    io1.core_ad,    ea);
      chk({name, "/pt"},    io1.core_pt,    ep);
      chk({name, "/rnd"},   io1.core_rnd,   er);
   endtask

   task automatic load1(input bit gaps, input bit start_last, output int cycles);
      int  j;
      logic v;
      j = 0; cycles = 0;
      while (j < 128 && cycles < 600) begin
         v = gaps ? (cycles % 2 == 1) : 1'b1;
         io1.load_valid = v;
         for (int s = 0; s < 3; s++) begin
            io1.key_si[s]   = v ? sk[s][j] : 1'($urandom);
            io1.nonce_si[s] = v ? sn[s][j] : 1'($urandom);
            io1.ad_si[s]    = v ? sa[s][j] : 1'($urandom);
            io1.pt_si[s]    = v ? sp[s][j] : 1'($urandom);
         end
         for (int r = 0; r < 7; r++) io1.rnd_si[r] = v ? sr[r][j] : 1'($urandom);
         io1.start = start_last && v && (j == 127);
         if (v && j == 127) chk("load/in_ready_last_beat", io1.in_ready, 1);
         @(posedge clk); #1;
         if (v) j++;
         cycles++;
      end
      io1.load_valid = 1'b0;
      io1.start      = 1'b0;
      if (j < 128) chk("load/timeout", j, 128);
   endtask

   task automatic start1();
      io1.start = 1'b1;
      @(posedge clk); #1;
      io1.start = 1'b0;
      chk("start/core_start", io1.core_start, 1);
      chk("start/busy", io1.busy, 1);
      @(posedge clk); #1;
      chk("start/core_start_one_cycle", io1.core_start, 0);
   endtask

   task automatic done1(input logic [79:0] ct, input logic [127:0] tag);
      io1.core_ct = ct; io1.core_tag = tag; io1.core_done = 1'b1;
      @(posedge clk); #1;
      io1.core_done = 1'b0;
      io1.core_ct   = {$urandom, $urandom, 16'($urandom)};
      io1.core_tag  = rnd128();
   endtask

   // mode 0: always ready; 1: random backpressure + stray load_valid; 2: 5-cycle stall at beat 40
   task automatic drain1(input logic [79:0] ct, input logic [127:0] tag, input int mode,
                         input int i0, input int stop_at);
      int i, cyc, stall;
      logic rdy;
      i = i0; cyc = 0; stall = 0;
      while (i < stop_at && cyc < 2000) begin
         case (mode)
            1:       rdy = ($urandom_range(0, 3) != 0);
            2:       rdy = !(i == 40 && stall < 5);
            default: rdy = 1'b1;
         endcase
         if (!rdy) stall++;
         io1.out_ready  = rdy;
         io1.load_valid = (mode == 1) ? 1'($urandom) : 1'b0;
         io1.key_si     = 3'($urandom);
         chk("drain/ct_valid",  io1.ct_valid,  (i < 80));
         chk("drain/tag_valid", io1.tag_valid, (i < 128));
         chk("drain/ct_so",     io1.ct_so,     (i < 80) ? ct[i] : 1'b0);
         chk("drain/tag_so",    io1.tag_so,    tag[i]);
         @(posedge clk); #1;
         if (rdy) i++;
         cyc++;
      end
      io1.out_ready  = 1'b0;
      io1.load_valid = 1'b0;
      if (i < stop_at) chk("drain/timeout", i, stop_at);
      if (stop_at == 128) begin
         chk("drain/end_in_ready", io1.in_ready, 1);
         chk("drain/end_busy", io1.busy, 0);
         chk("drain/end_valids", {io1.ct_valid, io1.tag_valid}, 0);
      end
   endtask

   task automatic txn1(input logic [79:0] ct, input logic [127:0] tag, input int mode);
      int c;
      rand_seqs();
      load1(0, 0, c);
      check_bus1("txn");
      start1();
      done1(ct, tag);
      drain1(ct, tag, mode, 0, 128);
      check_bus1("txn_post");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      logic [127:0] kv, t;
      logic [447:0] er8;
      logic [79:0]  ct8;
      logic [127:0] tag8;

      tbl[0] = '{80'h1, 128'h1 << 127, 0,   1, 1, 1, 0};
      tbl[1] = '{80'h1, 128'h1 << 127, 79,  1, 1, 0, 0};
      tbl[2] = '{80'h1, 128'h1 << 127, 80,  0, 1, 0, 0};
      tbl[3] = '{80'h1, 128'h1 << 127, 127, 0, 1, 0, 1};
      tbl[4] = '{80'h8000_0000_0000_0000_0000, 128'h0, 79, 1, 1, 1, 0};
      tbl[5] = '{{80{1'b1}}, {128{1'b1}}, 80, 0, 1, 0, 1};
      tbl[6] = '{80'h0, 128'h20, 5, 1, 1, 0, 1};

      io1.load_valid = 0; io1.key_si = '0; io1.nonce_si = '0; io1.ad_si = '0; io1.pt_si = '0;
      io1.rnd_si = '0; io1.start = 0; io1.core_done = 0; io1.core_ct = '0; io1.core_tag = '0;
      io1.out_ready = 0;
      io8.load_valid = 0; io8.key_si = '0; io8.nonce_si = '0; io8.ad_si = '0; io8.pt_si = '0;
      io8.rnd_si = '0; io8.start = 0; io8.core_done = 0; io8.core_ct = '0; io8.core_tag = '0;
      io8.out_ready = 0;
      rst = 1; rst8 = 1;
      repeat (2) @(posedge clk);
      #1; rst = 0; rst8 = 0;

      // reset state
      chk("rst/in_ready", io1.in_ready, 1);
      chk("rst/busy", io1.busy, 0);
      chk("rst/valids", {io1.ct_valid, io1.tag_valid, io1.core_start}, 0);
      chk("rst/buses", {io1.core_key, io1.core_rnd, io1.ct_so, io1.tag_so}, 0);
      chk("rst8/in_ready", io8.in_ready, 1);

      // start in LOAD is ignored
      io1.start = 1; @(posedge clk); #1; io1.start = 0;
      chk("t3/load_start_core_start", io1.core_start, 0);
      chk("t3/load_start_state", {io1.in_ready, io1.busy}, 2'b10);

      // known vectors, start raised on the final beat (ignored)
      rand_seqs();
      kv = 128'h000102030405060708090A0B0C0D0E0F;
      sk[0] = unplace(kv, 128);
      sa[0] = unplace({48'h0, 80'h00112233445566778899}, 80);
      sp[0] = unplace({48'h0, 80'hFEDCBA98765432100123}, 80);
      sr[0] = unplace({64'h0, 64'h0123456789ABCDEF}, 64);
      load1(0, 1, c);
      chk("t1/cycles", c, 128);
      chk("t1/in_ready", io1.in_ready, 0);
      chk("t1/key0", io1.core_key[127:0], kv);
      chk("t1/ad0", io1.core_ad[79:0], 80'h00112233445566778899);
      chk("t1/pt0", io1.core_pt[79:0], 80'hFEDCBA98765432100123);
      chk("t1/rnd0", io1.core_rnd[63:0], 64'h0123456789ABCDEF);
      check_bus1("t1");
      chk("t3/last_beat_start", io1.core_start, 0);
      @(posedge clk); #1;
      chk("t3/armed_hold", {io1.core_start, io1.in_ready, io1.busy}, 0);

      // core_done and load_valid while ARMED are ignored
      io1.core_done = 1; io1.core_ct = 80'hFFFF;
      @(posedge clk); #1; io1.core_done = 0;
      chk("ign/done_armed", {io1.busy, io1.ct_valid, io1.tag_valid}, 0);
      io1.load_valid = 1;
      repeat (3) begin
         io1.key_si = 3'($urandom); io1.ad_si = 3'($urandom); io1.rnd_si = 7'($urandom);
         @(posedge clk); #1;
      end
      io1.load_valid = 0;
      check_bus1("ign/lv_armed");

      // start -> drain of ct=1, tag=MSB with a 5-cycle stall at beat 40
      start1();
      done1(80'h1, 128'h1 << 127);
      drain1(80'h1, 128'h1 << 127, 2, 0, 128);

      // gapped load of the same vectors
      load1(1, 0, c);
      chk("t2/cycles", c, 256);
      chk("t2/in_ready", io1.in_ready, 0);
      chk("t2/key0", io1.core_key[127:0], kv);
      check_bus1("t2");
      start1();
      done1(80'h5A5A, 128'hC3);
      drain1(80'h5A5A, 128'hC3, 1, 0, 128);

      // table-driven drain probes
      for (int k = 0; k < 7; k++) begin
         rand_seqs();
         load1(0, 0, c);
         start1();
         done1(tbl[k].ct, tbl[k].tag);
         drain1(tbl[k].ct, tbl[k].tag, 0, 0, tbl[k].probe);
         chk($sformatf("tbl%0d/probe", k),
             {io1.ct_valid, io1.tag_valid, io1.ct_so, io1.tag_so},
             {tbl[k].ectv, tbl[k].etv, tbl[k].ect, tbl[k].etg});
         drain1(tbl[k].ct, tbl[k].tag, 0, tbl[k].probe, 128);
      end

      // randomized transactions with backpressure
      for (int k = 0; k < 4; k++)
         txn1({$urandom, $urandom, 16'($urandom)}, rnd128(), 1);

      // reset mid-drain at d=40
      rand_seqs();
      load1(0, 0, c);
      start1();
      done1(80'hABCDE, 128'h12345);
      drain1(80'hABCDE, 128'h12345, 0, 0, 40);
      rst = 1; @(posedge clk); #1; rst = 0;
      chk("t6/in_ready", io1.in_ready, 1);
      chk("t6/busy_valids", {io1.busy, io1.ct_valid, io1.tag_valid, io1.core_start}, 0);
      chk("t6/so", {io1.ct_so, io1.tag_so}, 0);
      chk("t6/buses", {io1.core_key, io1.core_nonce, io1.core_ad, io1.core_pt, io1.core_rnd}, 0);

      // reset on the same cycle as start suppresses core_start
      rand_seqs();
      load1(0, 0, c);
      io1.start = 1; rst = 1;
      @(posedge clk); #1; io1.start = 0; rst = 0;
      chk("t6/start_suppressed", {io1.core_start, io1.busy, io1.in_ready}, 3'b001);
      txn1(80'h3, 128'h7, 1);

      // W=8, one share
      for (int j = 0; j < 16; j++) begin
         io8.load_valid = 1;
         io8.key_si   = 8'(j);
         io8.nonce_si = 8'(16 + j);
         io8.ad_si    = (j < 10) ? 8'(8'hA0 + j) : 8'hFF;
         io8.pt_si    = (j < 10) ? 8'(8'h50 + j) : 8'hEE;
         for (int r = 0; r < 7; r++) io8.rnd_si[r*8 +: 8] = (j < 8) ? 8'(r*16 + j) : 8'hCC;
         if (j == 15) chk("t5/in_ready_beat15", io8.in_ready, 1);
         @(posedge clk); #1;
      end
      io8.load_valid = 0;
      chk("t5/in_ready", io8.in_ready, 0);
      chk("t5/key", io8.core_key, 128'h000102030405060708090A0B0C0D0E0F);
      chk("t5/nonce", io8.core_nonce, 128'h101112131415161718191A1B1C1D1E1F);
      chk("t5/ad", io8.core_ad, 80'hA0A1A2A3A4A5A6A7A8A9);
      chk("t5/pt", io8.core_pt, 80'h50515253545556575859);
      for (int r = 0; r < 7; r++)
         for (int j = 0; j < 8; j++) er8[r*64 + 56 - 8*j +: 8] = 8'(r*16 + j);
      chk("t5/rnd", io8.core_rnd, er8);
      io8.start = 1; @(posedge clk); #1; io8.start = 0;
      chk("t5/core_start", io8.core_start, 1);
      ct8  = 80'h0102030405060708090A;
      tag8 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
      io8.core_ct = ct8; io8.core_tag = tag8; io8.core_done = 1;
      @(posedge clk); #1; io8.core_done = 0; io8.core_ct = '0; io8.core_tag = '0;
      chk("t5/first_ct", io8.ct_so, 8'h0A);
      chk("t5/first_tag", io8.tag_so, 8'h0F);
      for (int i = 0; i < 16; i++) begin
         io8.out_ready = 1;
         t = tag8 >> (8*i);
         chk("t5/ct_valid", io8.ct_valid, (i < 10));
         chk("t5/tag_valid", io8.tag_valid, 1);
         chk("t5/ct_so", io8.ct_so, (i < 10) ? ct8[8*i +: 8] : 8'h00);
         chk("t5/tag_so", io8.tag_so, t[7:0]);
         @(posedge clk); #1;
      end
      io8.out_ready = 0;
      chk("t5/end", {io8.in_ready, io8.busy, io8.ct_valid, io8.tag_valid}, 4'b1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
